// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: op codes, RAM size masks,
// FSM state encoding and small decode helpers.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_SB  = 4'd5,
        OP_SH  = 4'd6,
        OP_SW  = 4'd7,
        OP_LWL = 4'd8,
        OP_LWR = 4'd9,
        OP_SWL = 4'd10,
        OP_SWR = 4'd11
    } lsu_op_e;

    // RAM access size: 1x = word, 01 = half, 00 = byte
    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_BYTE   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > 4'd11;
    endfunction

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==0
    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return a != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] native_mask(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return MASK_BYTE;
            OP_LH, OP_LHU, OP_SH: return MASK_HALF;
            default:              return MASK_WORD;
        endcase
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op <= 4'd4) || (op == OP_LWL) || (op == OP_LWR);
    endfunction

endpackage

// File: rtl/lsu_merge.sv
// Combinational LWL/LWR register merge. word_i is the aligned RAM word,
// k_i the byte offset within it; left_i selects LWL, else LWR.
module lsu_merge
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] rt_old_i,
    input  logic [1:0]  k_i,
    input  logic        left_i,
    output logic [31:0] merged_o
);

    logic [4:0]  lwl_sh;
    logic [2:0]  kp1;
    logic [5:0]  keep_sh;
    logic [4:0]  lwr_sh;
    logic [31:0] lwl_val;
    logic [31:0] lwr_val;

    // Shift amounts can reach 32 for LWL k=3 (keep nothing of rt_old), so keep_sh is 6 bits wide
    always_comb begin
        lwl_sh   = {2'd3 - k_i, 3'b000};
        kp1      = {1'b0, k_i} + 3'd1;
        keep_sh  = {kp1, 3'b000};
        lwr_sh   = {k_i, 3'b000};
        lwl_val  = (word_i << lwl_sh) | (rt_old_i & (32'hFFFF_FFFF >> keep_sh));
        lwr_val  = (word_i >> lwr_sh) | (rt_old_i & ~(32'hFFFF_FFFF >> lwr_sh));
        merged_o = left_i ? lwl_val : lwr_val;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control unit: one request at a time, alignment/op checking,
// RAM sequencing including byte-serial SWL/SWR and LWL/LWR merge.
// Optional macro LSU_ALIGN_CHECK_EN: reject misaligned LH/LHU/SH/LW/SW
// with resp_err and no RAM access. Without it, only illegal ops error.
module lsu_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [1:0]  ram_mask,
    output logic        ram_signed_ext,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    lsu_state_e  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        req_bad;
    logic [1:0]  k;
    logic [1:0]  last_cnt;
    logic        is_swl;
    logic        is_sw_unal;
    logic [31:0] merged;

    assign k          = addr_q[1:0];
    assign is_swl     = (op_q == OP_SWL);
    assign is_sw_unal = (op_q == OP_SWL) || (op_q == OP_SWR);
    // SWL writes k+1 bytes walking down, SWR writes 4-k bytes walking up
    assign last_cnt   = is_swl ? k : (2'd3 - k);

`ifdef LSU_ALIGN_CHECK_EN
    assign req_bad = op_illegal(req_op) || misaligned(req_op, req_addr[1:0]);
`else
    assign req_bad = op_illegal(req_op);
`endif

    lsu_merge u_merge (
        .word_i   (ram_rdata),
        .rt_old_i (rt_q),
        .k_i      (k),
        .left_i   (op_q == OP_LWL),
        .merged_o (merged)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Next-state and request/response register updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rt_d    = rt_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rt_d    = req_rt_old;
                    rdata_d = 32'h0;
                    cnt_d   = 2'd0;
                    err_d   = req_bad;
                    state_d = req_bad ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (is_sw_unal) begin
                    cnt_d   = 2'd0;
                    state_d = ST_BYTE;
                end else begin
                    if (is_load(op_q))
                        rdata_d = ((op_q == OP_LWL) || (op_q == OP_LWR)) ? merged : ram_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_BYTE: begin
                if (cnt_q == last_cnt) state_d = ST_RESP;
                else                   cnt_d   = cnt_q + 2'd1;
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM port decode from the state register so reset kills ram_we at once
    always_comb begin
        ram_we         = 1'b0;
        ram_addr       = 32'h0;
        ram_mask       = MASK_BYTE;
        ram_signed_ext = 1'b0;
        ram_wdata      = 32'h0;
        if (state_q == ST_ACCESS) begin
            case (op_q)
                OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
                    ram_addr       = addr_q;
                    ram_mask       = native_mask(op_q);
                    ram_signed_ext = (op_q == OP_LB) || (op_q == OP_LH);
                end
                OP_LWL, OP_LWR: begin
                    ram_addr = {addr_q[31:2], 2'b00};
                    ram_mask = MASK_WORD;
                end
                OP_SB, OP_SH, OP_SW: begin
                    ram_we    = 1'b1;
                    ram_addr  = addr_q;
                    ram_mask  = native_mask(op_q);
                    ram_wdata = wdata_q;
                end
                default: ;
            endcase
        end else if (state_q == ST_BYTE) begin
            ram_we = 1'b1;
            if (is_swl) begin
                ram_addr  = addr_q - {30'h0, cnt_q};
                ram_wdata = {24'h0, wdata_q[{2'd3 - cnt_q, 3'b000} +: 8]};
            end else begin
                ram_addr  = addr_q + {30'h0, cnt_q};
                ram_wdata = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
            end
        end
    end

    // State and captured-request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rt_q    <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rt_q    <= rt_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-addressed RAM model, reference model of the
// load/store rules, directed plan cases then randomized transactions.
module tb_lsu_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_rt_old, resp_rdata;
    logic        ram_we, ram_signed_ext;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [1:0]  ram_mask;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_mask(ram_mask),
        .ram_signed_ext(ram_signed_ext), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM model (256 bytes, address wraps), little-endian
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic       tb_wr = 1'b0;
    logic [7:0] tb_wa, tb_wd;
    int         we_cnt = 0;
    logic [7:0] ra0, ra1, ra2, ra3, b0, b1, b2, b3;

    assign ra0 = ram_addr[7:0];
    assign ra1 = ra0 + 8'd1;
    assign ra2 = ra0 + 8'd2;
    assign ra3 = ra0 + 8'd3;

    always_comb begin
        b0 = mem[ra0]; b1 = mem[ra1]; b2 = mem[ra2]; b3 = mem[ra3];
        if (ram_mask[1])      ram_rdata = {b3, b2, b1, b0};
        else if (ram_mask[0]) ram_rdata = {{16{ram_signed_ext & b1[7]}}, b1, b0};
        else                  ram_rdata = {{24{ram_signed_ext & b0[7]}}, b0};
    end

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ra0] <= ram_wdata[7:0];
            if (ram_mask != MASK_BYTE) mem[ra1] <= ram_wdata[15:8];
            if (ram_mask[1]) begin
                mem[ra2] <= ram_wdata[23:16];
                mem[ra3] <= ram_wdata[31:24];
            end
            we_cnt <= we_cnt + 1;
        end else if (tb_wr) begin
            mem[tb_wa] <= tb_wd;
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd;
    logic        last_err;
    int          last_lat, last_nwe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rb(input int x);
        return ref_mem[x & 255];
    endfunction

    // Reference: result, error, latency (edges from request to resp_valid), RAM write count
    task automatic ref_exec(input logic [3:0] op, input logic [31:0] addr, wd, rt,
                            output logic [31:0] rd, output logic e, output int lat, output int nwe);
        int a, al, k;
        logic [15:0] h;
        a = int'(addr[7:0]); al = a & 252; k = int'(addr[1:0]);
        rd = 0; lat = 2; nwe = 0;
        e = (op > 4'd11);
`ifdef LSU_ALIGN_CHECK_EN
        if ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0]) e = 1'b1;
        if ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00) e = 1'b1;
`endif
        if (e) lat = 1;
        else begin
            h = {rb(a + 1), rb(a)};
            case (op)
                OP_LB:  rd = {{24{h[7]}}, h[7:0]};
                OP_LBU: rd = {24'h0, h[7:0]};
                OP_LH:  rd = {{16{h[15]}}, h};
                OP_LHU: rd = {16'h0, h};
                OP_LW:  rd = {rb(a + 3), rb(a + 2), h};
                OP_LWL: begin
                    rd = rt;
                    for (int j = 0; j <= k; j++) rd[8*(3-k+j) +: 8] = rb(al + j);
                end
                OP_LWR: begin
                    rd = rt;
                    for (int j = k; j <= 3; j++) rd[8*(j-k) +: 8] = rb(al + j);
                end
                OP_SB, OP_SH, OP_SW: begin
                    nwe = 1;
                    for (int j = 0; j < ((op == OP_SB) ? 1 : (op == OP_SH) ? 2 : 4); j++)
                        ref_mem[(a + j) & 255] = wd[8*j +: 8];
                end
                OP_SWL: begin
                    for (int i = 0; i <= k; i++) ref_mem[(a - i) & 255] = wd[8*(3-i) +: 8];
                    nwe = k + 1; lat = 2 + nwe;
                end
                default: begin
                    for (int i = 0; i <= 3 - k; i++) ref_mem[(a + i) & 255] = wd[8*i +: 8];
                    nwe = 4 - k; lat = 2 + nwe;
                end
            endcase
        end
    endtask

    task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_wr = 1'b1; tb_wa = a; tb_wd = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 tb_wr = 1'b0;
    endtask

    task automatic preload_plan();
        wr_byte(8'h10, 8'h55); wr_byte(8'h11, 8'h66); wr_byte(8'h12, 8'h77);
        wr_byte(8'h13, 8'h88); wr_byte(8'h14, 8'h55); wr_byte(8'h15, 8'h66);
    endtask

    // Present a request, wait (bounded) for resp_valid, record latency/result
    task automatic send(input logic [3:0] op, input logic [31:0] addr, wd, rt);
        int w0;
        w0 = we_cnt;
        @(negedge clk);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt_old = rt;
        last_lat = 0;
        do begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            last_lat++;
        end while (!resp_valid && last_lat < 40);
        chk("resp_timeout", {31'h0, resp_valid}, 32'h1);
        last_rd = resp_rdata; last_err = resp_err; last_nwe = we_cnt - w0;
    endtask

    // Stall the response for 'hold' cycles, then handshake
    task automatic ack(input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'h0, resp_valid}, 32'h1);
            chk("hold_rdata", resp_rdata, last_rd);
            chk("hold_ready", {31'h0, req_ready}, 32'h0);
        end
        @(negedge clk) resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        chk("ack_valid", {31'h0, resp_valid}, 32'h0);
        chk("ack_ready", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] addr, wd, rt, input int hold);
        logic [31:0] erd; logic ee; int elat, enwe;
        ref_exec(op, addr, wd, rt, erd, ee, elat, enwe);
        send(op, addr, wd, rt);
        chk({tag, ".rdata"}, last_rd, erd);
        chk({tag, ".err"}, {31'h0, last_err}, {31'h0, ee});
        chk({tag, ".lat"}, last_lat, elat);
        chk({tag, ".nwe"}, last_nwe, enwe);
        ack(hold);
    endtask

    initial begin
        int nbad;
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0; req_rt_old = 32'h0;
        #1 rst = 1'b1;
        #2;
        chk("rst.req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst.ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst.ram_addr", ram_addr, 32'h0);
        chk("rst.ram_wdata", ram_wdata, 32'h0);
        chk("rst.ram_mask", {30'h0, ram_mask}, 32'h0);
        chk("rst.ram_sext", {31'h0, ram_signed_ext}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 chk("post_rst.req_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 256; i++) wr_byte(i[7:0], 8'($urandom));
        preload_plan();

        run("LB13", OP_LB, 32'h13, 32'h0, 32'h0, 0);
        chk("plan.LB13", last_rd, 32'hFFFF_FF88);
        chk("plan.LB13.lat", last_lat, 2);
        run("LBU13", OP_LBU, 32'h13, 32'h0, 32'h0, 0);
        chk("plan.LBU13", last_rd, 32'h0000_0088);
        run("LH12", OP_LH, 32'h12, 32'h0, 32'h0, 0);
        chk("plan.LH12", last_rd, 32'hFFFF_8877);
        run("LWL11", OP_LWL, 32'h11, 32'h0, 32'hAABB_CCDD, 0);
        chk("plan.LWL11", last_rd, 32'h6655_CCDD);
        run("LWR11", OP_LWR, 32'h11, 32'h0, 32'hAABB_CCDD, 0);
        chk("plan.LWR11", last_rd, 32'hAA88_7766);

        run("SWL12", OP_SWL, 32'h12, 32'h1122_3344, 32'h0, 0);
        chk("plan.SWL12.nwe", last_nwe, 3);
        run("LW10a", OP_LW, 32'h10, 32'h0, 32'h0, 0);
        chk("plan.SWL12.word", last_rd, 32'h8811_2233);
        preload_plan();
        run("SWR12", OP_SWR, 32'h12, 32'h1122_3344, 32'h0, 0);
        chk("plan.SWR12.nwe", last_nwe, 2);
        run("LW10b", OP_LW, 32'h10, 32'h0, 32'h0, 0);
        chk("plan.SWR12.word", last_rd, 32'h3344_6655);
        preload_plan();

        run("LW12", OP_LW, 32'h12, 32'h0, 32'h0, 0);
`ifdef LSU_ALIGN_CHECK_EN
        chk("plan.LW12.err", {31'h0, last_err}, 32'h1);
        chk("plan.LW12.nwe", last_nwe, 0);
        chk("plan.LW12.lat", last_lat, 1);
`else
        chk("plan.LW12.rd", last_rd, 32'h6655_8877);
`endif
        run("ILL13", 4'd13, 32'h10, 32'h0, 32'h0, 0);
        chk("plan.ILL.err", {31'h0, last_err}, 32'h1);
        chk("plan.ILL.lat", last_lat, 1);

        // Stalled response with a new request waiting behind it
        send(OP_LBU, 32'h13, 32'h0, 32'h0);
        chk("stall.rd", last_rd, 32'h0000_0088);
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LB; req_addr = 32'h12;
        ack(5);
        @(posedge clk); #1 req_valid = 1'b0;
        chk("stall.accept", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        chk("stall.next_valid", {31'h0, resp_valid}, 32'h1);
        chk("stall.next_rd", resp_rdata, 32'h0000_0077);
        last_rd = resp_rdata;
        ack(0);

        // Reset during the second byte of SWR 0x10
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SWR; req_addr = 32'h10; req_wdata = 32'hA1B2_C3D4;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid.we_before", {31'h0, ram_we}, 32'h1);
        chk("rstmid.addr_before", ram_addr, 32'h11);
        rst = 1'b1;
        #1;
        chk("rstmid.we", {31'h0, ram_we}, 32'h0);
        chk("rstmid.idle", {31'h0, req_ready}, 32'h1);
        chk("rstmid.resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk) rst = 1'b0;
        ref_mem[8'h10] = 8'hD4;
        for (int i = 16; i < 20; i++) chk("rstmid.mem", {24'h0, mem[i]}, {24'h0, ref_mem[i]});
        chk("rstmid.byte10", {24'h0, mem[16]}, 32'hD4);

        // Randomized traffic, including illegal ops and misaligned addresses
        for (int n = 0; n < 60; n++)
            run("rnd", 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom_range(0, 2));

        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem_image", nbad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
